// File: rtl/dds_mod_scheduler.sv
// Symbol-rate scheduler for the DDS modulator: divides clk down to the symbol
// period, pulls one bit per symbol and drives phase increment/offset/amplitude.
module dds_mod_scheduler #(
  parameter int DIV_W  = 16,
  parameter int PINC_W = 32,
  parameter int OFS_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        mode,
  input  logic [PINC_W-1:0] f0_inc,
  input  logic [PINC_W-1:0] f1_inc,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              bit_ready,
  output logic [PINC_W-1:0] phase_inc,
  output logic [OFS_W-1:0]  phase_ofs,
  output logic              amp_en,
  output logic              sym_tick,
  output logic              busy,
  output logic              underrun
);

  // state | meaning
  // IDLE  | no session; outputs forced to zero
  // LOAD  | waiting for the first bit of the session
  // RUN   | counting symbols, one bit taken per boundary
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  localparam logic [1:0]       M_ASK  = 2'd0;
  localparam logic [1:0]       M_FSK  = 2'd1;
  localparam logic [1:0]       M_BPSK = 2'd2;
  localparam logic [1:0]       M_CAR  = 2'd3;
  localparam logic [OFS_W-1:0] OFS_PI = {1'b1, {(OFS_W-1){1'b0}}};

  state_t              r_state, w_state;
  logic [DIV_W-1:0]    r_cnt, w_cnt;
  logic [DIV_W-1:0]    r_div, w_div;
  logic [1:0]          r_mode, w_mode;
  logic [PINC_W-1:0]   r_f0, w_f0;
  logic [PINC_W-1:0]   r_f1, w_f1;
  logic                r_stop_pend, w_stop_pend;
  logic [PINC_W-1:0]   r_phase_inc, w_phase_inc;
  logic [OFS_W-1:0]    r_phase_ofs, w_phase_ofs;
  logic                r_amp_en, w_amp_en;
  logic                r_underrun, w_underrun;

  logic [DIV_W-1:0]    w_div_eff;
  logic                w_tc;
  logic [PINC_W-1:0]   w_map_inc;
  logic [OFS_W-1:0]    w_map_ofs;
  logic                w_map_amp;

  // Periods below two cycles would leave no room between boundaries.
  assign w_div_eff = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign w_tc      = (r_cnt == '0);

  assign sym_tick  = (r_state == S_RUN) && w_tc;
  assign busy      = (r_state != S_IDLE);
  assign bit_ready = ((r_state == S_LOAD) && !stop) ||
                     (sym_tick && (r_mode != M_CAR) && !r_stop_pend);

  assign phase_inc = r_phase_inc;
  assign phase_ofs = r_phase_ofs;
  assign amp_en    = r_amp_en;
  assign underrun  = r_underrun;

  always_comb begin
    w_map_inc = r_f0;
    w_map_ofs = '0;
    w_map_amp = 1'b1;
    case (r_mode)
      M_ASK:   w_map_amp = bit_data;
      M_FSK:   w_map_inc = bit_data ? r_f1 : r_f0;
      M_BPSK:  w_map_ofs = bit_data ? OFS_PI : '0;
      default: ;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_div       = r_div;
    w_mode      = r_mode;
    w_f0        = r_f0;
    w_f1        = r_f1;
    w_stop_pend = r_stop_pend;
    w_phase_inc = r_phase_inc;
    w_phase_ofs = r_phase_ofs;
    w_amp_en    = r_amp_en;
    w_underrun  = r_underrun;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_div       = w_div_eff;
          w_mode      = mode;
          w_f0        = f0_inc;
          w_f1        = f1_inc;
          w_underrun  = 1'b0;
          w_stop_pend = 1'b0;
          if (mode == M_CAR) begin
            w_state     = S_RUN;
            w_cnt       = w_div_eff - 1'b1;
            w_phase_inc = f0_inc;
            w_phase_ofs = '0;
            w_amp_en    = 1'b1;
          end else begin
            w_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (stop) begin
          w_state = S_IDLE;
        end else if (bit_valid) begin
          w_state     = S_RUN;
          w_cnt       = r_div - 1'b1;
          w_phase_inc = w_map_inc;
          w_phase_ofs = w_map_ofs;
          w_amp_en    = w_map_amp;
        end
      end
      S_RUN: begin
        if (stop) w_stop_pend = 1'b1;
        if (w_tc) begin
          w_cnt = r_div - 1'b1;
          if (r_stop_pend) begin
            w_state     = S_IDLE;
            w_cnt       = '0;
            w_stop_pend = 1'b0;
            w_phase_inc = '0;
            w_phase_ofs = '0;
            w_amp_en    = 1'b0;
          end else if (r_mode != M_CAR) begin
            if (bit_valid) begin
              w_phase_inc = w_map_inc;
              w_phase_ofs = w_map_ofs;
              w_amp_en    = w_map_amp;
            end else begin
              // Missing bit: silence this symbol but keep the carrier settings.
              w_underrun = 1'b1;
              w_amp_en   = 1'b0;
            end
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_mode      <= '0;
      r_f0        <= '0;
      r_f1        <= '0;
      r_stop_pend <= 1'b0;
      r_phase_inc <= '0;
      r_phase_ofs <= '0;
      r_amp_en    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_div       <= w_div;
      r_mode      <= w_mode;
      r_f0        <= w_f0;
      r_f1        <= w_f1;
      r_stop_pend <= w_stop_pend;
      r_phase_inc <= w_phase_inc;
      r_phase_ofs <= w_phase_ofs;
      r_amp_en    <= w_amp_en;
      r_underrun  <= w_underrun;
    end
  end

endmodule

// File: tb/tb_dds_mod_scheduler.sv
// Directed bench for dds_mod_scheduler; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_dds_mod_scheduler;
  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [15:0] cfg_div;
  logic [1:0]  mode;
  logic [31:0] f0_inc, f1_inc;
  logic        bit_valid, bit_data;
  logic        bit_ready, amp_en, sym_tick, busy, underrun;
  logic [31:0] phase_inc;
  logic [11:0] phase_ofs;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  dds_mod_scheduler #(.DIV_W(16), .PINC_W(32), .OFS_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_div(cfg_div),
    .mode(mode), .f0_inc(f0_inc), .f1_inc(f1_inc), .bit_valid(bit_valid),
    .bit_data(bit_data), .bit_ready(bit_ready), .phase_inc(phase_inc),
    .phase_ofs(phase_ofs), .amp_en(amp_en), .sym_tick(sym_tick), .busy(busy),
    .underrun(underrun)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, simulation still running");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; cfg_div = 16'd0; mode = 2'd0;
    f0_inc = 32'h0; f1_inc = 32'h0; bit_valid = 1'b1; bit_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp_n++;
      if ({busy, bit_ready, amp_en, sym_tick, underrun} !== 5'b0 ||
          phase_inc !== 32'h0 || phase_ofs !== 12'h0) begin
        err_n++;
        $display("FAIL reset_idle c=%0d: busy=%b rdy=%b amp=%b tick=%b und=%b inc=%h ofs=%h, required all 0",
                 c, busy, bit_ready, amp_en, sym_tick, underrun, phase_inc, phase_ofs);
      end
    end
  endtask

  task automatic test_fsk();
    logic [31:0] exp_inc [3];
    logic        bits [3];
    bits[0] = 1; bits[1] = 0; bits[2] = 1;
    exp_inc[0] = 32'h200; exp_inc[1] = 32'h100; exp_inc[2] = 32'h200;
    start = 1; mode = 2'd1; cfg_div = 16'd5; f0_inc = 32'h100; f1_inc = 32'h200;
    bit_valid = 1; bit_data = bits[0];
    @(negedge clk);
    start = 0;
    cmp_n++;
    if (busy !== 1'b1 || bit_ready !== 1'b1 || phase_inc !== 32'h0 || amp_en !== 1'b0) begin
      err_n++;
      $display("FAIL fsk_load: busy=%b rdy=%b inc=%h amp=%b, required 1 1 0 0", busy, bit_ready, phase_inc, amp_en);
    end
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        cmp_n++;
        if (phase_inc !== exp_inc[s] || amp_en !== 1'b1 || phase_ofs !== 12'h0 ||
            sym_tick !== (c == 4) || bit_ready !== (c == 4 && s < 2)) begin
          err_n++;
          $display("FAIL fsk_sym s=%0d c=%0d: inc=%h amp=%b ofs=%h tick=%b rdy=%b, required inc=%h amp=1 ofs=0 tick=%b rdy=%b",
                   s, c, phase_inc, amp_en, phase_ofs, sym_tick, bit_ready, exp_inc[s], (c == 4), (c == 4 && s < 2));
        end
        if (c == 4 && s < 2) bit_data = bits[s+1];
        if (s == 2) stop = (c == 0);
      end
    end
    @(negedge clk);
    cmp_n++;
    if (busy !== 1'b0 || phase_inc !== 32'h0 || amp_en !== 1'b0) begin
      err_n++;
      $display("FAIL fsk_end: busy=%b inc=%h amp=%b, required 0 0 0", busy, phase_inc, amp_en);
    end
  endtask

  task automatic test_bpsk();
    start = 1; mode = 2'd2; cfg_div = 16'd4; f0_inc = 32'h1234;
    bit_valid = 1; bit_data = 0;
    @(negedge clk);
    start = 0;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        cmp_n++;
        if (phase_ofs !== (s == 1 ? 12'd2048 : 12'd0) || amp_en !== 1'b1 ||
            phase_inc !== 32'h1234 || sym_tick !== (c == 3)) begin
          err_n++;
          $display("FAIL bpsk s=%0d c=%0d: ofs=%0d amp=%b inc=%h tick=%b, required ofs=%0d amp=1 inc=1234 tick=%b",
                   s, c, phase_ofs, amp_en, phase_inc, sym_tick, (s == 1 ? 2048 : 0), (c == 3));
        end
        if (s == 0 && c == 3) bit_data = 1;
        if (s == 1) stop = (c == 0);
      end
    end
    @(negedge clk);
    cmp_n++;
    if (busy !== 1'b0 || phase_ofs !== 12'h0) begin
      err_n++;
      $display("FAIL bpsk_end: busy=%b ofs=%0d, required 0 0", busy, phase_ofs);
    end
  endtask

  task automatic test_underrun();
    logic vld [4];
    vld[0] = 1; vld[1] = 1; vld[2] = 0; vld[3] = 0;
    start = 1; mode = 2'd0; cfg_div = 16'd3; f0_inc = 32'h300;
    bit_valid = 1; bit_data = 1;
    @(negedge clk);
    start = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        cmp_n++;
        if (amp_en !== (s != 2) || underrun !== (s >= 2) || phase_inc !== 32'h300) begin
          err_n++;
          $display("FAIL ask_underrun s=%0d c=%0d: amp=%b und=%b inc=%h, required amp=%b und=%b inc=300",
                   s, c, amp_en, underrun, phase_inc, (s != 2), (s >= 2));
        end
        if (c == 2) begin
          bit_valid = (s == 0 || s == 2);
          bit_data  = 1;
        end
        if (s == 3) stop = (c == 0);
      end
    end
    bit_valid = vld[3];
    @(negedge clk);
    cmp_n++;
    if (busy !== 1'b0 || underrun !== 1'b1) begin
      err_n++;
      $display("FAIL underrun_sticky: busy=%b und=%b, required 0 1", busy, underrun);
    end
    start = 1;
    @(negedge clk);
    start = 0;
    cmp_n++;
    if (underrun !== 1'b0 || busy !== 1'b1) begin
      err_n++;
      $display("FAIL underrun_clear: und=%b busy=%b, required 0 1", underrun, busy);
    end
    stop = 1;
    @(negedge clk);
    stop = 0;
    cmp_n++;
    if (busy !== 1'b0) begin
      err_n++;
      $display("FAIL stop_in_load: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_stop();
    start = 1; mode = 2'd0; cfg_div = 16'd8; f0_inc = 32'h40;
    bit_valid = 1; bit_data = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmp_n++;
      if (sym_tick !== (c == 7) || bit_ready !== 1'b0 || busy !== 1'b1 || amp_en !== 1'b1) begin
        err_n++;
        $display("FAIL stop_symbol c=%0d: tick=%b rdy=%b busy=%b amp=%b, required tick=%b rdy=0 busy=1 amp=1",
                 c, sym_tick, bit_ready, busy, amp_en, (c == 7));
      end
      stop = (c == 2);
    end
    @(negedge clk);
    cmp_n++;
    if (busy !== 1'b0 || amp_en !== 1'b0 || sym_tick !== 1'b0) begin
      err_n++;
      $display("FAIL stop_idle: busy=%b amp=%b tick=%b, required 0 0 0", busy, amp_en, sym_tick);
    end
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    cmp_n++;
    if (busy !== 1'b1) begin
      err_n++;
      $display("FAIL start_stop_together: busy=%b, required 1", busy);
    end
    stop = 1;
    @(negedge clk);
    stop = 0;
  endtask

  task automatic test_carrier_reset();
    start = 1; mode = 2'd3; cfg_div = 16'd0; f0_inc = 32'hABCD; bit_valid = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) cfg_div = 16'd7;
      cmp_n++;
      if (sym_tick !== (c % 2 == 1) || bit_ready !== 1'b0 || amp_en !== 1'b1 ||
          phase_inc !== 32'hABCD || busy !== 1'b1) begin
        err_n++;
        $display("FAIL carrier c=%0d: tick=%b rdy=%b amp=%b inc=%h busy=%b, required tick=%b rdy=0 amp=1 inc=abcd busy=1",
                 c, sym_tick, bit_ready, amp_en, phase_inc, busy, (c % 2 == 1));
      end
      @(negedge clk);
    end
    stop = 1;
    reset = 1;
    @(negedge clk);
    reset = 0; stop = 0;
    cmp_n++;
    if ({busy, amp_en, sym_tick, bit_ready, underrun} !== 5'b0 ||
        phase_inc !== 32'h0 || phase_ofs !== 12'h0) begin
      err_n++;
      $display("FAIL reset_in_run: busy=%b amp=%b tick=%b rdy=%b und=%b inc=%h ofs=%h, required all 0",
               busy, amp_en, sym_tick, bit_ready, underrun, phase_inc, phase_ofs);
    end
  endtask

  initial begin
    test_reset();
    test_fsk();
    test_bpsk();
    test_underrun();
    test_stop();
    test_carrier_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
